mac_stream_dot: RTL and testbench
=================================

// Module: mac_stream_dot
// PURPOSE
//  Streaming fixed-point dot-product engine and parametrised successor of the single-DSP MAC accumulator.
//  - Accepts (a,b) term pairs over a valid/ready handshake and multiplies them.
//  - Accumulates products in a guard-bit accumulator; each vector ends on in_last or after MAX_LEN terms.
//  - Emits one rounded, saturated Qm.FRAC_W result per vector; feeds the filter/equaliser datapath.
// PARAMETERS
//  DATA_W   16  signed width of a_in/b_in
//  FRAC_W   14  fractional bits of inputs and output (Q2.14 default)
//  ACC_W    40  accumulator width; must be >= 2*DATA_W
//  OUT_W    16  signed width of out_data
//  MAX_LEN  64  max terms per vector; the term that hits it is treated as last
//  CNT_W    $clog2(MAX_LEN+1)  width of out_count
// PORTS
//  clk        in   1       system clock, all state rising-edge
//  reset      in   1       synchronous, active-high; clears all state
//  clear      in   1       synchronous datapath flush (same effect as reset, one cycle)
//  in_valid   in   1       a_in/b_in/in_last valid
//  in_ready   out  1       term accepted when in_valid && in_ready
//  a_in       in   DATA_W  signed operand A
//  b_in       in   DATA_W  signed operand B
//  in_last    in   1       term is final term of current vector
//  out_valid  out  1       result held on out_* until out_ready
//  out_ready  in   1       downstream accepts result
//  out_data   out  OUT_W   rounded, saturated result
//  out_acc    out  ACC_W   raw full-precision accumulator value (Q.2*FRAC_W)
//  out_count  out  CNT_W   terms in this vector (1..MAX_LEN)
//  out_sat    out  1       out_data was clipped
// BEHAVIOUR
//  - Reset/clear: in_ready=0 in that cycle; out_valid=0; out_data, out_acc, out_count and out_sat are 0; pipeline valids, accumulator and term counter are 0.
//  - Global advance adv = !(out_valid && !out_ready); in_ready = adv && !reset && !clear.
//  - On !adv the whole pipeline freezes, including when no last term is in flight.
//  - Pipeline with 3 stages, all gated by adv:
//    - S1 registers a, b, last and valid.
//    - S2 registers the 2*DATA_W signed product.
//    - S3 is the accumulator.
//  - Latency: a last term accepted in cycle t gives out_valid=1 in cycle t+3.
//  - Accumulate: product sign-extended to ACC_W.
//    - First term of a vector: acc <= prod.
//    - Otherwise: acc <= acc + prod, wrapping modulo 2^ACC_W.
//  - Term counter: increments per S3 term. When it reaches MAX_LEN that term is forced last, even without in_last.
//  - At a last term the output is computed from acc+prod:
//    - r = (sum + 2^(FRAC_W-1)) >>> FRAC_W (round half up).
//    - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat=1 iff clipped.
//    - Load out_data/out_acc/out_count/out_sat; set out_valid=1; the next term starts a new vector.
//  - Output hold: out_* stay stable while out_valid && !out_ready.
//  - out_valid && out_ready with a new last term at S3 in the same cycle: new result loads and out_valid stays 1 (back-to-back).
//  - out_valid && out_ready with no last term at S3: out_valid goes 0 next cycle.
//  - clear or reset mid-vector: partial sum and in-flight terms are discarded.
//  - clear or reset together with in_valid: the term is not accepted.
// STRUCTURE
//  - Package mac_pkg:
//    - q_fmt_t typedef and the DATA_W/FRAC_W defaults.
//    - function round_sat(acc, frac_w, out_w) returning {sat, value}.
//  - Sub-module mac_round_sat: combinational round and saturate stage, instantiated once at S3.
// TESTING
//  - Single term: a=0x4000, b=0x2000, last -> out_data=0x2000, count=1, sat=0, out_valid at t+3.
//  - 4-term dot: a={4000,4000,C000,2000}, b={2000,2000,2000,4000} -> out_data=0x4000, count=4.
//  - Rounding: a=0x0001, b=0x2000, last -> out_acc=0x2000, out_data=0x0001.
//  - Saturation:
//    - 4x (0x7FFF*0x7FFF) -> out_data=0x7FFF, sat=1.
//    - 4x (0x8000*0x7FFF) -> out_data=0x8000, sat=1.
//  - Backpressure: out_ready=0 for 10 cycles after result.
//    - Required: in_ready=0 and out_* stable throughout.
//    - After release: next vector's result correct, with no lost or duplicated terms.
//  - MAX_LEN=4, 6 terms of 0x4000*0x4000 with last on term 6 -> results 0x7FFF(sat) count=4, then 0x8000->sat 0x7FFF count=2.
//  - clear asserted mid-vector after 2 terms, then 1-term vector 0x4000*0x4000 -> out_data=0x4000, count=1.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and the fixed-point round/saturate helper for the streaming MAC datapath.
package mac_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefFracW = 14;

  // Working widths of round_sat; callers sign-extend into / slice out of these.
  localparam int unsigned RsAccW = 64;
  localparam int unsigned RsOutW = 32;

  typedef logic signed [DefDataW-1:0] q_fmt_t;

  // Round half up by frac_w bits, then clip to a signed out_w-bit range.
  // Returns {sat, value}; value is valid in its low out_w bits.
  function automatic logic [RsOutW:0] round_sat(input logic signed [RsAccW-1:0] acc,
                                                input int unsigned            frac_w,
                                                input int unsigned            out_w);
    logic signed [RsAccW-1:0] half;
    logic signed [RsAccW-1:0] r;
    logic signed [RsAccW-1:0] hi;
    logic signed [RsAccW-1:0] lo;
    logic                     sat;
    half = RsAccW'(1) << (frac_w - 1);
    hi   = (RsAccW'(1) << (out_w - 1)) - RsAccW'(1);
    lo   = -(RsAccW'(1) << (out_w - 1));
    r    = (acc + half) >>> frac_w;
    sat  = 1'b0;
    if (r > hi) begin
      r   = hi;
      sat = 1'b1;
    end else if (r < lo) begin
      r   = lo;
      sat = 1'b1;
    end
    return {sat, r[RsOutW-1:0]};
  endfunction

endpackage

// File: rtl/mac_round_sat.sv
// Combinational round-half-up and saturate from the accumulator format to the output format.
module mac_round_sat
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned FRAC_W = 14,
  parameter int unsigned OUT_W  = 16
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] data_o,
  output logic                    sat_o
);

  logic [RsOutW:0] res;
  logic            unused_res_hi;

  assign res           = round_sat(RsAccW'(acc_i), FRAC_W, OUT_W);
  assign data_o        = res[OUT_W-1:0];
  assign sat_o         = res[RsOutW];
  assign unused_res_hi = ^res[RsOutW-1:OUT_W];

endmodule

// File: rtl/mac_stream_dot.sv
// Streaming dot-product engine: 3-stage register/multiply/accumulate pipeline with one
// rounded, saturated result per vector and a single global stall on output backpressure.
module mac_stream_dot
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned FRAC_W  = DefFracW,
  parameter int unsigned ACC_W   = 40,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic signed [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]         out_count,
  output logic                     out_sat
);

  localparam int unsigned     ProdW  = 2 * DATA_W;
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_LEN);

  logic adv, flush, take;

  logic                     s1_valid_q, s1_last_q;
  logic signed [DATA_W-1:0] s1_a_q, s1_b_q;
  logic                     s2_valid_q, s2_last_q;
  logic signed [ProdW-1:0]  s2_prod_q;

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic signed [ACC_W-1:0]  out_acc_q, out_acc_d;
  logic [CNT_W-1:0]         out_count_q, out_count_d;
  logic                     out_sat_q, out_sat_d;

  logic signed [ACC_W-1:0]  prod_ext, sum;
  logic [CNT_W-1:0]         cnt_inc;
  logic                     term_last, fire;
  logic signed [OUT_W-1:0]  rs_data;
  logic                     rs_sat;

  // A result held without out_ready stalls every stage, not only the output.
  assign adv      = !(out_valid_q && !out_ready);
  assign flush    = reset || clear;
  assign in_ready = adv && !flush;
  assign take     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (flush) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_prod_q  <= '0;
    end else if (adv) begin
      s1_valid_q <= take;
      s1_last_q  <= in_last;
      s1_a_q     <= a_in;
      s1_b_q     <= b_in;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_prod_q  <= ProdW'(s1_a_q) * ProdW'(s1_b_q);
    end
  end

  mac_round_sat #(
    .ACC_W (ACC_W),
    .FRAC_W(FRAC_W),
    .OUT_W (OUT_W)
  ) u_round_sat (
    .acc_i (sum),
    .data_o(rs_data),
    .sat_o (rs_sat)
  );

  always_comb begin
    prod_ext  = ACC_W'(s2_prod_q);
    cnt_inc   = cnt_q + CNT_W'(1);
    // A zero count marks the first term of a vector, so the stale accumulator is ignored.
    sum       = (cnt_q == '0) ? prod_ext : acc_q + prod_ext;
    term_last = s2_last_q || (cnt_inc == MaxCnt);
    fire      = adv && s2_valid_q;

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;

    if (fire && term_last) begin
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b1;
      out_data_d  = rs_data;
      out_acc_d   = sum;
      out_count_d = cnt_inc;
      out_sat_d   = rs_sat;
    end else begin
      if (fire) begin
        acc_d = sum;
        cnt_d = cnt_inc;
      end
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_mac_stream_dot.sv
// Bench for mac_stream_dot: directed cases plus random traffic scored against a vector-level
// arithmetic model, on a default instance (MAX_LEN=64) and a MAX_LEN=4 instance.
module tb_mac_stream_dot;

  localparam int unsigned DW = 16;
  localparam int unsigned FW = 14;
  localparam int unsigned AW = 40;
  localparam int unsigned OW = 16;

  logic clk = 1'b0;
  logic reset, clear;
  logic in_valid[2], in_last[2], out_ready[2], in_ready[2], out_valid[2], out_sat[2];
  logic [DW-1:0] a_in[2], b_in[2], out_data[2];
  logic [AW-1:0] out_acc[2];
  logic [6:0] out_count0;
  logic [2:0] out_count1;

  always #5 clk = ~clk;

  mac_stream_dot u_dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .a_in(a_in[0]), .b_in(b_in[0]),
    .in_last(in_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_acc(out_acc[0]), .out_count(out_count0), .out_sat(out_sat[0])
  );

  mac_stream_dot #(.MAX_LEN(4)) u_dut4 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .a_in(a_in[1]), .b_in(b_in[1]),
    .in_last(in_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_acc(out_acc[1]), .out_count(out_count1), .out_sat(out_sat[1])
  );

  typedef struct {
    logic [15:0] data;
    logic [39:0] acc;
    int          cnt;
    logic        sat;
  } res_t;

  res_t   q0[$], q1[$];
  longint m_acc[2];
  int     m_cnt[2];
  int     max_len[2] = '{64, 4};
  bit     acc_flag[2];
  int     n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] cnt_of(input int d);
    return (d == 0) ? out_count0 : {4'b0, out_count1};
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Vector result straight from the arithmetic definition: round half up, then clip.
  function automatic res_t model_result(input longint sum, input int cnt);
    res_t   o;
    longint r, hi, lo;
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -(longint'(1) << (OW - 1));
    r  = (sum + (longint'(1) << (FW - 1))) >>> FW;
    o.sat = 1'b0;
    if (r > hi) begin r = hi; o.sat = 1'b1; end
    else if (r < lo) begin r = lo; o.sat = 1'b1; end
    o.data = r[15:0];
    o.acc  = sum[39:0];
    o.cnt  = cnt;
    return o;
  endfunction

  task automatic model_term(input int d, input logic [15:0] a, input logic [15:0] b,
                            input logic last);
    longint p;
    res_t   r;
    p = longint'($signed(a)) * longint'($signed(b));
    m_acc[d] = (m_cnt[d] == 0) ? p : m_acc[d] + p;
    m_acc[d] = (m_acc[d] << 24) >>> 24;  // wrap to a 40-bit two's complement value
    m_cnt[d]++;
    if (last || m_cnt[d] == max_len[d]) begin
      r = model_result(m_acc[d], m_cnt[d]);
      if (d == 0) q0.push_back(r); else q1.push_back(r);
      m_cnt[d] = 0;
      m_acc[d] = 0;
    end
  endtask

  task automatic model_flush(input int d);
    m_cnt[d] = 0;
    m_acc[d] = 0;
    if (d == 0) q0.delete(); else q1.delete();
  endtask

  task automatic score(input int d);
    res_t e;
    if (qsize(d) == 0) begin
      check($sformatf("spurious_out%0d", d), out_valid[d], 1'b0);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    check($sformatf("data%0d", d), out_data[d], e.data);
    check($sformatf("acc%0d", d), out_acc[d], e.acc);
    check($sformatf("count%0d", d), cnt_of(d), e.cnt);
    check($sformatf("sat%0d", d), out_sat[d], e.sat);
  endtask

  // One clock: observe handshakes on the falling edge, return 1 time unit after the rise.
  task automatic cycle();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      acc_flag[d] = 1'b0;
      if (reset || clear) begin
        check($sformatf("flush_in_ready%0d", d), in_ready[d], 1'b0);
        model_flush(d);
      end else begin
        if (in_valid[d] && in_ready[d]) begin
          acc_flag[d] = 1'b1;
          model_term(d, a_in[d], b_in[d], in_last[d]);
        end
        if (out_valid[d] && out_ready[d]) score(d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [15:0] a, input logic [15:0] b, input logic last);
    in_valid[d] = 1'b1;
    a_in[d]     = a;
    b_in[d]     = b;
    in_last[d]  = last;
    for (int k = 0; k < 200; k++) begin
      cycle();
      if (acc_flag[d]) break;
    end
    if (!acc_flag[d]) check($sformatf("send_timeout%0d", d), acc_flag[d], 1'b1);
    in_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (qsize(d) == 0) break;
      cycle();
    end
    check($sformatf("drain_left%0d", d), qsize(d), 0);
  endtask

  task automatic expect_out(input int d, input string tag, input logic [15:0] data,
                            input logic [39:0] acc, input int cnt, input logic sat);
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (out_valid[d]) break;
      cycle();
    end
    check({tag, "_valid"}, out_valid[d], 1'b1);
    check({tag, "_data"}, out_data[d], data);
    check({tag, "_acc"}, out_acc[d], acc);
    check({tag, "_count"}, cnt_of(d), cnt);
    check({tag, "_sat"}, out_sat[d], sat);
    cycle();
  endtask

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom);
      1:       return 16'h4000;
      2:       return 16'hC000;
      default: return 16'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b1;  // must not be accepted while reset is high
      a_in[d]      = 16'h4000;
      b_in[d]      = 16'h4000;
      in_last[d]   = 1'b1;
      out_ready[d] = 1'b1;
      acc_flag[d]  = 1'b0;
      m_acc[d]     = 0;
      m_cnt[d]     = 0;
    end
    cycle();
    cycle();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_out_valid%0d", d), out_valid[d], 1'b0);
      check($sformatf("rst_in_ready%0d", d), in_ready[d], 1'b0);
      check($sformatf("rst_data%0d", d), out_data[d], 16'h0);
      check($sformatf("rst_acc%0d", d), out_acc[d], 40'h0);
      check($sformatf("rst_count%0d", d), cnt_of(d), 0);
      check($sformatf("rst_sat%0d", d), out_sat[d], 1'b0);
      in_valid[d] = 1'b0;
    end
    reset = 1'b0;
    cycle();

    // Single term with latency: accepted in t, visible in t+3.
    in_valid[0] = 1'b1; a_in[0] = 16'h4000; b_in[0] = 16'h2000; in_last[0] = 1'b1;
    cycle();
    check("single_accept", acc_flag[0], 1'b1);
    in_valid[0] = 1'b0;
    check("lat_t1", out_valid[0], 1'b0);
    cycle();
    check("lat_t2", out_valid[0], 1'b0);
    cycle();
    check("lat_t3", out_valid[0], 1'b1);
    expect_out(0, "single", 16'h2000, 40'h0008000000, 1, 1'b0);
    drain(0);

    // Four-term dot product.
    send(0, 16'h4000, 16'h2000, 1'b0);
    send(0, 16'h4000, 16'h2000, 1'b0);
    send(0, 16'hC000, 16'h2000, 1'b0);
    send(0, 16'h2000, 16'h4000, 1'b1);
    expect_out(0, "dot4", 16'h4000, 40'h0010000000, 4, 1'b0);

    send(0, 16'h0001, 16'h2000, 1'b1);
    expect_out(0, "round", 16'h0001, 40'h0000002000, 1, 1'b0);

    for (int i = 0; i < 4; i++) send(0, 16'h7FFF, 16'h7FFF, i == 3);
    expect_out(0, "sat_pos", 16'h7FFF, 40'h00FFFC0004, 4, 1'b1);
    for (int i = 0; i < 4; i++) send(0, 16'h8000, 16'h7FFF, i == 3);
    expect_out(0, "sat_neg", 16'h8000, 40'hFF00020000, 4, 1'b1);
    drain(0);

    // Backpressure: result A held for 10 cycles while vector B sits frozen in the pipe.
    out_ready[0] = 1'b0;
    send(0, 16'h4000, 16'h2000, 1'b1);
    send(0, 16'h2000, 16'h4000, 1'b0);
    send(0, 16'h2000, 16'h2000, 1'b1);
    in_valid[0] = 1'b1; a_in[0] = 16'h4000; b_in[0] = 16'h4000; in_last[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (out_valid[0]) break;
      cycle();
    end
    for (int k = 0; k < 10; k++) begin
      check("bp_out_valid", out_valid[0], 1'b1);
      check("bp_in_ready", in_ready[0], 1'b0);
      check("bp_data", out_data[0], 16'h2000);
      check("bp_acc", out_acc[0], 40'h0008000000);
      cycle();
    end
    out_ready[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (acc_flag[0]) break;
    end
    check("bp_resume_accept", acc_flag[0], 1'b1);
    in_valid[0] = 1'b0;
    drain(0);

    // MAX_LEN=4 instance: six terms, last flagged only on the sixth.
    for (int i = 0; i < 4; i++) send(1, 16'h4000, 16'h4000, 1'b0);
    expect_out(1, "maxlen_a", 16'h7FFF, 40'h0040000000, 4, 1'b1);
    send(1, 16'h4000, 16'h4000, 1'b0);
    send(1, 16'h4000, 16'h4000, 1'b1);
    expect_out(1, "maxlen_b", 16'h7FFF, 40'h0020000000, 2, 1'b1);
    drain(1);

    // Clear mid-vector, with a valid term presented during the clear.
    send(0, 16'h7FFF, 16'h7FFF, 1'b0);
    send(0, 16'h7FFF, 16'h7FFF, 1'b0);
    clear = 1'b1;
    in_valid[0] = 1'b1; a_in[0] = 16'h1234; b_in[0] = 16'h4321; in_last[0] = 1'b1;
    cycle();
    clear = 1'b0;
    in_valid[0] = 1'b0;
    send(0, 16'h4000, 16'h4000, 1'b1);
    expect_out(0, "after_clear", 16'h4000, 40'h0010000000, 1, 1'b0);
    drain(0);

    // Random traffic with random backpressure and rare clears on both instances.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      clear = ($urandom_range(0, 299) == 0);
      for (int d = 0; d < 2; d++) begin
        if (!in_valid[d] || acc_flag[d]) begin
          in_valid[d] = ($urandom_range(0, 3) != 0);
          a_in[d]     = rand_op();
          b_in[d]     = rand_op();
          in_last[d]  = ($urandom_range(0, 5) == 0);
        end
        out_ready[d] = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end
    clear = 1'b0;
    drain(0);
    drain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
